// File: rtl/softmax_row_normalizer_if.sv
// softmax_row_normalizer_if: valid/ready stream with a row-end marker
interface softmax_row_normalizer_if #(parameter int W = 16);
  logic valid;
  logic ready;
  logic [W-1:0] data;
  logic last;
  modport master(output valid, data, last, input ready);
  modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/softmax_row_normalizer.sv
// softmax_row_normalizer: buffers a row of exponents, gets 1/sum from Reciprocal_Integer, streams Q1.15 probabilities.
// Define SOFTMAX_ROUND_EN for round-half-up scaling instead of truncation.
module softmax_row_normalizer #(
  parameter int EXP_W = 10,
  parameter int RECIP_W = 18,
  parameter int OUT_W = 16,
  parameter int MAX_LEN = 64
) (
  input  logic clk,
  input  logic rst,
  softmax_row_normalizer_if.slave i_in,
  softmax_row_normalizer_if.master o_out,
  output logic o_recip_en,
  output logic [EXP_W-1:0] o_sum_out,
  input  logic [RECIP_W-1:0] i_recip_in,
  output logic o_sum_sat,
  output logic o_len_ovf
);
  localparam int AW = $clog2(MAX_LEN);
  localparam int PW = EXP_W + RECIP_W;
  typedef enum logic [1:0] {LOAD, WAIT, EMIT} state_t;
  state_t r_state, w_next;
  logic [EXP_W-1:0] r_buf [MAX_LEN];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic [EXP_W-1:0] r_sum;
  logic [RECIP_W-1:0] r_recip;
  logic r_out_valid, r_out_last, r_sum_sat, r_len_ovf;
  logic [OUT_W-1:0] r_out_data;
  logic w_acc, w_row_end, w_done, w_load;
  logic [EXP_W:0] w_sum;
  logic [PW:0] w_prod;
  logic [OUT_W-1:0] w_p;
  assign w_acc = i_in.valid && r_state == LOAD;
  assign w_row_end = w_acc && (i_in.last || r_wr_ptr == (AW+1)'(MAX_LEN-1));
  assign w_done = r_out_valid && o_out.ready && r_out_last;
  assign w_load = r_state == EMIT && !w_done && (!r_out_valid || o_out.ready);
  assign w_sum = {1'b0, r_sum} + {1'b0, i_in.data};
`ifdef SOFTMAX_ROUND_EN
  assign w_prod = ((PW+1)'(r_buf[r_rd_ptr[AW-1:0]]) * (PW+1)'(r_recip) + (PW+1)'(1)) >> 1;
`else
  assign w_prod = ((PW+1)'(r_buf[r_rd_ptr[AW-1:0]]) * (PW+1)'(r_recip)) >> 1;
`endif
  // a zero row sum yields all-zero probabilities whatever the reciprocal returned
  assign w_p = r_sum == '0 ? '0 :
               w_prod > (PW+1)'(1 << (OUT_W-1)) ? OUT_W'(1 << (OUT_W-1)) : w_prod[OUT_W-1:0];
  assign i_in.ready = r_state == LOAD;
  assign o_recip_en = r_state == WAIT;
  assign o_sum_out = o_recip_en ? r_sum : '0;
  assign o_out.valid = r_out_valid;
  assign o_out.data = r_out_data;
  assign o_out.last = r_out_last;
  assign o_sum_sat = r_sum_sat;
  assign o_len_ovf = r_len_ovf;
  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      LOAD: w_next = w_row_end ? WAIT : LOAD;
      WAIT: w_next = EMIT;
      default: w_next = w_done ? LOAD : EMIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (w_acc) r_buf[r_wr_ptr[AW-1:0]] <= i_in.data;
  end
  always_ff @(posedge clk) begin
    if (rst || w_done) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_sum <= '0;
      r_recip <= '0;
      r_out_valid <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
      r_sum_sat <= 1'b0;
      r_len_ovf <= 1'b0;
    end else begin
      if (w_acc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_sum <= w_sum[EXP_W] ? '1 : w_sum[EXP_W-1:0];
        r_sum_sat <= r_sum_sat | w_sum[EXP_W];
        r_len_ovf <= r_len_ovf | (w_row_end & !i_in.last);
      end
      if (o_recip_en) r_recip <= i_recip_in;
      if (w_load) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_out_valid <= 1'b1;
        r_out_data <= w_p;
        r_out_last <= r_rd_ptr == r_wr_ptr - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_softmax_row_normalizer.sv
// tb_softmax_row_normalizer: directed row vectors with hand-computed sums and probabilities
module tb_softmax_row_normalizer;
  logic clk = 0;
  logic rst = 1;
  logic recip_en, sum_sat, len_ovf;
  logic [9:0] sum_out;
  logic [17:0] recip_in;
  int n_vec = 0;
  int n_bad = 0;
`ifdef SOFTMAX_ROUND_EN
  localparam logic [15:0] P3 = 16'd10923;
`else
  localparam logic [15:0] P3 = 16'd10922;
`endif
  typedef struct packed {
    int n;
    logic [3:0][9:0] e;
    logic [9:0] fe;
    logic [17:0] recip;
    logic [9:0] sum;
    logic [3:0][15:0] p;
    logic [15:0] fp;
    logic last, stall, sat, ovf;
  } vec_t;
  vec_t vt [7];
  vec_t v_rr;
  softmax_row_normalizer_if #(.W(10)) in_if();
  softmax_row_normalizer_if #(.W(16)) out_if();
  softmax_row_normalizer dut (
    .clk(clk), .rst(rst), .i_in(in_if), .o_out(out_if),
    .o_recip_en(recip_en), .o_sum_out(sum_out), .i_recip_in(recip_in),
    .o_sum_sat(sum_sat), .o_len_ovf(len_ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic send(input int n, input logic [3:0][9:0] e, input logic [9:0] fe, input logic last);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_if.valid = 1;
      in_if.data = i < 4 ? e[i] : fe;
      in_if.last = last && i == n - 1;
    end
    @(negedge clk);
    in_if.valid = 0;
    in_if.last = 0;
  endtask
  task automatic collect(input vec_t v);
    int got = 0;
    int cyc = 0;
    logic [15:0] held = '0;
    bit hold = 0;
    out_if.ready = 1;
    @(negedge clk);
    check("valid_t2", out_if.valid, 0);
    while (got < v.n && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("valid_t3", out_if.valid, 1);
      if (hold) check("hold_data", out_if.data, held);
      out_if.ready = !v.stall || cyc[0] == 1'b0;
      hold = out_if.valid && !out_if.ready;
      held = out_if.data;
      if (out_if.valid && out_if.ready) begin
        check("p", out_if.data, got < 4 ? v.p[got] : v.fp);
        check("last", out_if.last, got == v.n - 1);
        got++;
      end
    end
    check("out_count", got, v.n);
    out_if.ready = 1;
    @(negedge clk);
    check("ready_after", in_if.ready, 1);
    check("valid_after", out_if.valid, 0);
    check("sat_after", sum_sat, 0);
    check("ovf_after", len_ovf, 0);
  endtask
  task automatic run(input vec_t v);
    recip_in = v.recip;
    send(v.n, v.e, v.fe, v.last);
    check("ready_wait", in_if.ready, 0);
    check("recip_en", recip_en, 1);
    check("sum_out", sum_out, v.sum);
    check("sum_sat", sum_sat, v.sat);
    check("len_ovf", len_ovf, v.ovf);
    collect(v);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    in_if.valid = 0;
    in_if.data = 0;
    in_if.last = 0;
    out_if.ready = 1;
    recip_in = 0;
    vt[0] = '{n:2, e:{10'd0,10'd0,10'd1,10'd1}, fe:0, recip:32768, sum:2,
              p:{16'd0,16'd0,16'd16384,16'd16384}, fp:0, last:1, stall:0, sat:0, ovf:0};
    vt[1] = '{n:1, e:{10'd0,10'd0,10'd0,10'd16}, fe:0, recip:4096, sum:16,
              p:{16'd0,16'd0,16'd0,16'd32768}, fp:0, last:1, stall:0, sat:0, ovf:0};
    vt[2] = '{n:3, e:{10'd0,10'd1,10'd1,10'd1}, fe:0, recip:21845, sum:3,
              p:{16'd0,P3,P3,P3}, fp:0, last:1, stall:0, sat:0, ovf:0};
    vt[3] = '{n:3, e:{10'd0,10'd0,10'd0,10'd0}, fe:0, recip:12345, sum:0,
              p:{16'd0,16'd0,16'd0,16'd0}, fp:0, last:1, stall:0, sat:0, ovf:0};
    vt[4] = '{n:4, e:{10'd4,10'd3,10'd2,10'd1}, fe:0, recip:6554, sum:10,
              p:{16'd13108,16'd9831,16'd6554,16'd3277}, fp:0, last:1, stall:1, sat:0, ovf:0};
    vt[5] = '{n:1, e:{10'd0,10'd0,10'd0,10'd1000}, fe:0, recip:100, sum:1000,
              p:{16'd0,16'd0,16'd0,16'd32768}, fp:0, last:1, stall:0, sat:0, ovf:0};
    vt[6] = '{n:64, e:{10'd20,10'd20,10'd20,10'd20}, fe:20, recip:1, sum:1023,
              p:{16'd10,16'd10,16'd10,16'd10}, fp:10, last:0, stall:0, sat:1, ovf:1};
    v_rr  = '{n:2, e:{10'd0,10'd0,10'd2,10'd2}, fe:0, recip:16384, sum:4,
              p:{16'd0,16'd0,16'd16384,16'd16384}, fp:0, last:1, stall:0, sat:0, ovf:0};
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_if.ready, 1);
    check("rst_recip_en", recip_en, 0);
    check("rst_sum_out", sum_out, 0);
    check("rst_out_valid", out_if.valid, 0);
    check("rst_out_data", out_if.data, 0);
    check("rst_out_last", out_if.last, 0);
    check("rst_sum_sat", sum_sat, 0);
    check("rst_len_ovf", len_ovf, 0);
    rst = 0;
    for (int i = 0; i < 7; i++) run(vt[i]);
    recip_in = 6554;
    send(4, {10'd4,10'd3,10'd2,10'd1}, 10'd0, 1'b1);
    out_if.ready = 0;
    repeat (3) @(negedge clk);
    check("stall_valid", out_if.valid, 1);
    check("stall_data", out_if.data, 3277);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrst_valid", out_if.valid, 0);
    check("midrst_ready", in_if.ready, 1);
    check("midrst_last", out_if.last, 0);
    out_if.ready = 1;
    run(v_rr);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
